get_packet: RTL

- Host-side receive packet engine: the inverse of the host transmit packet engine.
- Consumes the byte stream delivered by the SIE receive port and validates the PID against its complement.
- Classifies the packet as handshake (ACK/NAK/STALL) or data (DATA0/DATA1), strips the trailing CRC16 bytes, writes the payload into the host RX FIFO, and reports a status word to the host transaction controller.

---
 rtl/get_packet_pkg.sv | 51 +++++
 rtl/get_packet_if.sv | 25 ++
 rtl/get_packet_crc_strip.sv | 33 +++
 rtl/get_packet.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/get_packet_pkg.sv
// Shared definitions for the host receive packet engine: PID codes, SIE
// stream codes, RxPktStatus bit positions, FSM state encoding and small
// stream-code helpers.
package get_packet_pkg;

  localparam logic [3:0] PID_OUT   = 4'h1;
  localparam logic [3:0] PID_IN    = 4'h9;
  localparam logic [3:0] PID_SOF   = 4'h5;
  localparam logic [3:0] PID_SETUP = 4'hD;
  localparam logic [3:0] PID_DATA0 = 4'h3;
  localparam logic [3:0] PID_DATA1 = 4'hB;
  localparam logic [3:0] PID_ACK   = 4'h2;
  localparam logic [3:0] PID_NAK   = 4'hA;
  localparam logic [3:0] PID_STALL = 4'hE;

  localparam logic [7:0] RX_START             = 8'd0;
  localparam logic [7:0] RX_STREAM            = 8'd1;
  localparam logic [7:0] RX_STOP              = 8'd2;
  localparam logic [7:0] RX_STOP_CRC_ERR      = 8'd3;
  localparam logic [7:0] RX_STOP_BITSTUFF_ERR = 8'd4;

  localparam int ST_CRC_ERROR       = 0;
  localparam int ST_BIT_STUFF_ERROR = 1;
  localparam int ST_RX_OVERFLOW     = 2;
  localparam int ST_NAK_RXED        = 3;
  localparam int ST_STALL_RXED      = 4;
  localparam int ST_ACK_RXED        = 5;
  localparam int ST_DATA_SEQUENCE   = 6;
  localparam int ST_RX_TIME_OUT     = 7;
  localparam int ST_PID_ERROR       = 8;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_PID, S_DATA, S_WAIT_STOP, S_FIN
  } state_t;

  // Any of the three stop codes terminates a packet.
  function automatic logic is_stop(input logic [7:0] code);
    return (code == RX_STOP) || (code == RX_STOP_CRC_ERR) ||
           (code == RX_STOP_BITSTUFF_ERR);
  endfunction

  // Status bits carried by the stop code itself.
  function automatic logic [8:0] stop_err(input logic [7:0] code);
    logic [8:0] m;
    m = '0;
    if (code == RX_STOP_CRC_ERR)      m[ST_CRC_ERROR]       = 1'b1;
    if (code == RX_STOP_BITSTUFF_ERR) m[ST_BIT_STUFF_ERROR] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/get_packet_if.sv
// Receive-engine bus: host control/status, SIE byte stream and RX FIFO
// write port. slave = the engine, master = whoever drives it.
interface get_packet_if;
  logic       getPacketEn;
  logic       getPacketRdy;
  logic [7:0] RxByteIn;
  logic [7:0] RxStreamStatusIn;
  logic       RxDataValid;
  logic [3:0] RxPID;
  logic [8:0] RxPktStatus;
  logic [7:0] fifoData;
  logic       fifoWEn;
  logic       fifoFull;
  logic [9:0] RxByteCount;

  modport master (
    output getPacketEn, RxByteIn, RxStreamStatusIn, RxDataValid, fifoFull,
    input  getPacketRdy, RxPID, RxPktStatus, fifoData, fifoWEn, RxByteCount
  );

  modport slave (
    input  getPacketEn, RxByteIn, RxStreamStatusIn, RxDataValid, fifoFull,
    output getPacketRdy, RxPID, RxPktStatus, fifoData, fifoWEn, RxByteCount
  );
endinterface

// File: rtl/get_packet_crc_strip.sv
// Two-byte hold pipe. The last two bytes of a data packet are its CRC16,
// so a payload byte is only released once two newer bytes have arrived.
module get_packet_crc_strip (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       flush,
  input  logic [7:0] din,
  output logic [1:0] held,
  output logic       emit,
  output logic [7:0] emit_data
);
  logic [7:0] b0, b1;

  // A push into a full pipe pushes the oldest byte out.
  assign emit      = push && (held == 2'd2);
  assign emit_data = b0;

  // Shift register with occupancy count; flush wins over push.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      held <= 2'd0;
      b0   <= 8'd0;
      b1   <= 8'd0;
    end else if (push) begin
      case (held)
        2'd0: begin b0 <= din; held <= 2'd1; end
        2'd1: begin b1 <= din; held <= 2'd2; end
        default: begin b0 <= b1; b1 <= din; end
      endcase
    end
  end
endmodule

// File: rtl/get_packet.sv
// Host receive packet engine: checks PID, classifies handshake/data,
// strips CRC16, writes payload into the RX FIFO and reports status.
// Optional: GET_PACKET_BYTE_COUNT_EN exposes the payload write count on
// RxByteCount; otherwise RxByteCount is tied to 0.
module get_packet
  import get_packet_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 720,
  parameter int MAX_PKT_BYTES  = 64
) (
  input logic         clk,
  input logic         rst,
  get_packet_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [9:0]    CMAX = 10'(MAX_PKT_BYTES);

  state_t        state, state_n;
  logic          rdy, rdy_n;
  logic [3:0]    pid, pid_n;
  logic [8:0]    st, st_n;
  logic [7:0]    wdata, wdata_n;
  logic          wen, wen_n;
  logic [TW-1:0] timer, timer_n;
  logic [9:0]    wr_cnt, wr_cnt_n;

  logic       push, flush, emit;
  logic [1:0] held;
  logic [7:0] emit_data;

  logic [7:0] code, rx;
  logic       tmo;
  assign code = bus.RxStreamStatusIn;
  assign rx   = bus.RxByteIn;
  assign tmo  = (timer == TMAX);

  get_packet_crc_strip u_strip (
    .clk(clk), .rst(rst), .push(push), .flush(flush), .din(rx),
    .held(held), .emit(emit), .emit_data(emit_data)
  );

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      rdy    <= 1'b1;
      pid    <= 4'd0;
      st     <= 9'd0;
      wdata  <= 8'd0;
      wen    <= 1'b0;
      timer  <= '0;
      wr_cnt <= 10'd0;
    end else begin
      state  <= state_n;
      rdy    <= rdy_n;
      pid    <= pid_n;
      st     <= st_n;
      wdata  <= wdata_n;
      wen    <= wen_n;
      timer  <= timer_n;
      wr_cnt <= wr_cnt_n;
    end
  end

  // Next state, next outputs and hold-pipe control.
  always_comb begin
    state_n  = state;
    rdy_n    = rdy;
    pid_n    = pid;
    st_n     = st;
    wdata_n  = wdata;
    wen_n    = 1'b0;
    timer_n  = timer;
    wr_cnt_n = wr_cnt;
    push     = 1'b0;
    flush    = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.getPacketEn) begin
          rdy_n    = 1'b0;
          st_n     = 9'd0;
          wr_cnt_n = 10'd0;
          timer_n  = '0;
          flush    = 1'b1;
          state_n  = S_WAIT_PID;
        end
      end
      S_WAIT_PID: begin
        if (bus.RxDataValid) begin
          timer_n = '0;
          state_n = S_WAIT_STOP;
          if (code == RX_START) begin
            pid_n = rx[3:0];
            if (rx[7:4] != ~rx[3:0]) st_n[ST_PID_ERROR] = 1'b1;
            else begin
              case (rx[3:0])
                PID_DATA0, PID_DATA1: begin
                  st_n[ST_DATA_SEQUENCE] = (rx[3:0] == PID_DATA1);
                  state_n = S_DATA;
                end
                PID_ACK:   st_n[ST_ACK_RXED]   = 1'b1;
                PID_NAK:   st_n[ST_NAK_RXED]   = 1'b1;
                PID_STALL: st_n[ST_STALL_RXED] = 1'b1;
                default:   st_n[ST_PID_ERROR]  = 1'b1;
              endcase
            end
          end else begin
            st_n[ST_PID_ERROR] = 1'b1;
          end
        end else if (tmo) begin
          st_n[ST_RX_TIME_OUT] = 1'b1;
          state_n = S_FIN;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      S_DATA: begin
        if (bus.RxDataValid) begin
          timer_n = '0;
          if (code == RX_STREAM) begin
            push = 1'b1;
            if (emit) begin
              if (bus.fifoFull || (wr_cnt >= CMAX)) begin
                st_n[ST_RX_OVERFLOW] = 1'b1;
              end else begin
                wen_n    = 1'b1;
                wdata_n  = emit_data;
                wr_cnt_n = wr_cnt + 10'd1;
              end
            end
          end else if (is_stop(code)) begin
            flush = 1'b1;
            st_n  = st | stop_err(code);
            if (held != 2'd2) st_n[ST_CRC_ERROR] = 1'b1;
            state_n = S_FIN;
          end else if (code == RX_START) begin
            flush = 1'b1;
            st_n[ST_PID_ERROR] = 1'b1;
            state_n = S_FIN;
          end
        end else if (tmo) begin
          flush = 1'b1;
          st_n[ST_RX_TIME_OUT] = 1'b1;
          state_n = S_FIN;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      S_WAIT_STOP: begin
        if (bus.RxDataValid) begin
          timer_n = '0;
          if (code == RX_STREAM) begin
            if (st[ST_ACK_RXED] || st[ST_NAK_RXED] || st[ST_STALL_RXED])
              st_n[ST_PID_ERROR] = 1'b1;
          end else if (is_stop(code)) begin
            st_n    = st | stop_err(code);
            state_n = S_FIN;
          end
        end else if (tmo) begin
          st_n[ST_RX_TIME_OUT] = 1'b1;
          state_n = S_FIN;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      S_FIN: begin
        rdy_n   = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign bus.getPacketRdy = rdy;
  assign bus.RxPID        = pid;
  assign bus.RxPktStatus  = st;
  assign bus.fifoData     = wdata;
  assign bus.fifoWEn      = wen;
`ifdef GET_PACKET_BYTE_COUNT_EN
  assign bus.RxByteCount  = wr_cnt;
`else
  assign bus.RxByteCount  = 10'd0;
`endif
endmodule
